// File: rtl/uart_axil_bridge_pkg.sv
// Shared constants and state type for the UART to AXI-Lite command bridge.
package uart_axil_bridge_pkg;

    // Command bytes that open a frame
    localparam logic [7:0] CMD_WR = 8'h57;
    localparam logic [7:0] CMD_RD = 8'h52;

    // Single-byte error replies
    localparam logic [7:0] ST_BADCMD  = 8'hEE;
    localparam logic [7:0] ST_TIMEOUT = 8'hEF;

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StData,
        StWrReq,
        StWrResp,
        StRdReq,
        StRdResp,
        StTxStatus,
        StTxData
    } state_e;

    // States in which command bytes are accepted from the receiver
    function automatic logic rx_phase(state_e s);
        return (s == StIdle) || (s == StAddr) || (s == StData);
    endfunction

endpackage

// File: rtl/axil_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface axil_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/uart_axil_bridge.sv
// UART byte-stream to AXI-Lite bridge. Frames: cmd, 4 address bytes (MSB first), then 4 data
// bytes for writes. Replies with a status byte, plus 4 read-data bytes for reads.
// Optional feature: define UART_AXIL_BRIDGE_RX_TIMEOUT_EN to abandon partial frames after
// RX_TIMEOUT_CYCLES idle cycles, replying 0xEF.
module uart_axil_bridge
    import uart_axil_bridge_pkg::*;
#(
    parameter int unsigned AXIL_ADDR_WIDTH   = 32,
    parameter int unsigned AXIL_DATA_WIDTH   = 32,
    parameter int unsigned RX_TIMEOUT_CYCLES = 100000
) (
    input  logic       clk_i,
    input  logic       arstn_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic       rx_ready_o,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    axil_if.master     m_axil
);

    state_e                     state_q, state_d;
    logic                       rd_q, rd_d;
    logic [1:0]                 cnt_q, cnt_d;
    logic [AXIL_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [AXIL_DATA_WIDTH-1:0] data_q, data_d;
    logic [7:0]                 status_q, status_d;
    logic                       aw_done_q, aw_done_d;
    logic                       w_done_q, w_done_d;
    logic                       rx_ready_q;

    logic       rx_fire;
    logic       aw_valid, w_valid, ar_valid, b_ready, r_ready;
    logic       aw_fire, w_fire;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       timeout;

    assign rx_fire = rx_valid_i && rx_ready_q;

`ifdef UART_AXIL_BRIDGE_RX_TIMEOUT_EN
    localparam int unsigned IdleW = $clog2(RX_TIMEOUT_CYCLES + 1);

    logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;

    // Count consecutive idle cycles while a frame is partially received
    always_comb begin
        idle_cnt_d = '0;
        timeout    = 1'b0;
        if (((state_q == StAddr) || (state_q == StData)) && !rx_fire) begin
            if (idle_cnt_q == IdleW'(RX_TIMEOUT_CYCLES - 1)) begin
                timeout = 1'b1;
            end else begin
                idle_cnt_d = idle_cnt_q + IdleW'(1);
            end
        end
    end

    // Idle counter register
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    logic unused_timeout_cfg;
    assign timeout            = 1'b0;
    assign unused_timeout_cfg = ^RX_TIMEOUT_CYCLES;
`endif

    // Frame decode, AXI sequencing and response serialisation
    always_comb begin
        state_d   = state_q;
        rd_d      = rd_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        status_d  = status_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        aw_valid  = 1'b0;
        w_valid   = 1'b0;
        ar_valid  = 1'b0;
        b_ready   = 1'b0;
        r_ready   = 1'b0;
        aw_fire   = 1'b0;
        w_fire    = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;

        unique case (state_q)
            StIdle: begin
                if (rx_fire) begin
                    cnt_d = 2'd0;
                    if (rx_data_i == CMD_WR) begin
                        rd_d    = 1'b0;
                        state_d = StAddr;
                    end else if (rx_data_i == CMD_RD) begin
                        rd_d    = 1'b1;
                        state_d = StAddr;
                    end else begin
                        rd_d     = 1'b0;
                        status_d = ST_BADCMD;
                        state_d  = StTxStatus;
                    end
                end
            end
            StAddr: begin
                if (rx_fire) begin
                    addr_d = {addr_q[AXIL_ADDR_WIDTH-9:0], rx_data_i};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = rd_q ? StRdReq : StData;
                    end
                end
            end
            StData: begin
                if (rx_fire) begin
                    data_d = {data_q[AXIL_DATA_WIDTH-9:0], rx_data_i};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = StWrReq;
                    end
                end
            end
            StWrReq: begin
                // AW and W retire independently; leave once both have been taken
                aw_valid = !aw_done_q;
                w_valid  = !w_done_q;
                aw_fire  = aw_valid && m_axil.awready;
                w_fire   = w_valid && m_axil.wready;
                if (aw_fire) begin
                    aw_done_d = 1'b1;
                end
                if (w_fire) begin
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
                    state_d = StWrResp;
                end
            end
            StWrResp: begin
                b_ready = 1'b1;
                if (m_axil.bvalid) begin
                    status_d = {6'b0, m_axil.bresp};
                    state_d  = StTxStatus;
                end
            end
            StRdReq: begin
                ar_valid = 1'b1;
                if (m_axil.arready) begin
                    state_d = StRdResp;
                end
            end
            StRdResp: begin
                r_ready = 1'b1;
                if (m_axil.rvalid) begin
                    status_d = {6'b0, m_axil.rresp};
                    data_d   = m_axil.rdata;
                    state_d  = StTxStatus;
                end
            end
            StTxStatus: begin
                tx_valid = 1'b1;
                tx_data  = status_q;
                if (tx_ready_i) begin
                    cnt_d   = 2'd0;
                    state_d = rd_q ? StTxData : StIdle;
                end
            end
            StTxData: begin
                tx_valid = 1'b1;
                tx_data  = data_q[AXIL_DATA_WIDTH-1 -: 8];
                if (tx_ready_i) begin
                    data_d = {data_q[AXIL_DATA_WIDTH-9:0], 8'h00};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Timeout only fires in StAddr/StData, where no AXI traffic is in flight
        if (timeout) begin
            rd_d     = 1'b0;
            cnt_d    = 2'd0;
            status_d = ST_TIMEOUT;
            state_d  = StTxStatus;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q    <= StIdle;
            rd_q       <= 1'b0;
            cnt_q      <= 2'd0;
            addr_q     <= '0;
            data_q     <= '0;
            status_q   <= 8'h00;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            rx_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            status_q   <= status_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            // Registered so it stays low during reset and rises one cycle after release
            rx_ready_q <= rx_phase(state_d);
        end
    end

    assign rx_ready_o = rx_ready_q;
    assign tx_valid_o = tx_valid;
    assign tx_data_o  = tx_data;

    assign m_axil.awaddr  = addr_q;
    assign m_axil.awprot  = 3'b000;
    assign m_axil.awvalid = aw_valid;
    assign m_axil.wdata   = data_q;
    assign m_axil.wstrb   = '1;
    assign m_axil.wvalid  = w_valid;
    assign m_axil.bready  = b_ready;
    assign m_axil.araddr  = addr_q;
    assign m_axil.arprot  = 3'b000;
    assign m_axil.arvalid = ar_valid;
    assign m_axil.rready  = r_ready;

endmodule

// File: tb/tb_uart_axil_bridge.sv
// Bench for uart_axil_bridge: directed vector table, reset/timeout sequences and random frames
// checked against a frame-level model with its own memory image.
module tb_uart_axil_bridge;

    localparam int unsigned TimeoutCycles = 40;

    logic       clk = 1'b0;
    logic       arstn = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    axil_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    uart_axil_bridge #(
        .AXIL_ADDR_WIDTH  (32),
        .AXIL_DATA_WIDTH  (32),
        .RX_TIMEOUT_CYCLES(TimeoutCycles)
    ) dut (
        .clk_i     (clk),
        .arstn_i   (arstn),
        .rx_data_i (rx_data),
        .rx_valid_i(rx_valid),
        .rx_ready_o(rx_ready),
        .tx_data_o (tx_data),
        .tx_valid_o(tx_valid),
        .tx_ready_i(tx_ready),
        .m_axil    (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Slave / sink state
    logic [31:0] mem [logic [31:0]];
    int          aw_dly = 0, w_dly = 0, ar_dly = 0, tx_stall = 0;
    bit          force_slverr = 1'b0;
    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
    logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
    logic [3:0]  cap_wstrb;
    logic [2:0]  cap_awprot, cap_arprot;
    bit          have_aw, have_w, have_ar, aw_p, w_p, ar_p, b_p, r_p;
    bit          prev_aw, prev_w, prev_ar, hold_on;
    int          aw_wait, w_wait, ar_wait, tx_wait;
    logic [7:0]  hold_val;
    int          proto_err = 0, hold_err = 0, busy_err = 0;
    logic [7:0]  txq [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] resp_of(input logic [31:0] a);
        return (force_slverr || (a[3:0] == 4'hC)) ? 2'b10 : 2'b00;
    endfunction

    // AXI-Lite slave and UART tx sink; everything is decided on the falling edge, so a
    // valid/ready pair seen here completes on the next rising edge.
    initial begin
        {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} = '0;
        bus.bresp = 2'b00;
        bus.rresp = 2'b00;
        bus.rdata = '0;
        tx_ready  = 1'b0;
        forever begin
            @(negedge clk);
            if (!arstn) begin
                {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} = '0;
                {have_aw, have_w, have_ar, aw_p, w_p, ar_p, b_p, r_p} = '0;
                {prev_aw, prev_w, prev_ar, hold_on} = '0;
                aw_wait = 0; w_wait = 0; ar_wait = 0; tx_wait = 0;
                tx_ready = 1'b0;
            end else begin
                if (aw_p) begin bus.awready = 1'b0; aw_p = 1'b0; end
                if (w_p) begin bus.wready = 1'b0; w_p = 1'b0; end
                if (ar_p) begin bus.arready = 1'b0; ar_p = 1'b0; end
                if (b_p) begin bus.bvalid = 1'b0; b_p = 1'b0; have_aw = 1'b0; have_w = 1'b0; end
                if (r_p) begin bus.rvalid = 1'b0; r_p = 1'b0; have_ar = 1'b0; end
                // Valid withdrawn before ready, or re-raised after its beat was taken
                if ((prev_aw && !bus.awvalid) || (prev_w && !bus.wvalid) ||
                    (prev_ar && !bus.arvalid)) proto_err++;
                if ((have_aw && bus.awvalid) || (have_w && bus.wvalid) ||
                    (have_ar && bus.arvalid)) proto_err++;
                if (rx_ready && (tx_valid || bus.awvalid || bus.wvalid || bus.arvalid ||
                                 bus.bready || bus.rready)) busy_err++;

                if (bus.awvalid && !have_aw) begin
                    if (aw_wait >= aw_dly) begin
                        bus.awready = 1'b1; aw_p = 1'b1; have_aw = 1'b1; aw_cnt++; aw_wait = 0;
                        cap_awaddr = bus.awaddr; cap_awprot = bus.awprot;
                    end else aw_wait++;
                end
                if (bus.wvalid && !have_w) begin
                    if (w_wait >= w_dly) begin
                        bus.wready = 1'b1; w_p = 1'b1; have_w = 1'b1; w_cnt++; w_wait = 0;
                        cap_wdata = bus.wdata; cap_wstrb = bus.wstrb;
                    end else w_wait++;
                end
                if (bus.arvalid && !have_ar) begin
                    if (ar_wait >= ar_dly) begin
                        bus.arready = 1'b1; ar_p = 1'b1; have_ar = 1'b1; ar_cnt++; ar_wait = 0;
                        cap_araddr = bus.araddr; cap_arprot = bus.arprot;
                    end else ar_wait++;
                end
                prev_aw = bus.awvalid && !bus.awready;
                prev_w  = bus.wvalid && !bus.wready;
                prev_ar = bus.arvalid && !bus.arready;

                if (have_aw && have_w && !aw_p && !w_p && !bus.bvalid) begin
                    bus.bvalid = 1'b1;
                    bus.bresp  = resp_of(cap_awaddr);
                    if (bus.bresp == 2'b00) mem[cap_awaddr] = cap_wdata;
                end
                if (bus.bvalid && bus.bready) b_p = 1'b1;
                if (have_ar && !ar_p && !bus.rvalid) begin
                    bus.rvalid = 1'b1;
                    bus.rresp  = resp_of(cap_araddr);
                    bus.rdata  = mem.exists(cap_araddr) ? mem[cap_araddr] : 32'h0;
                end
                if (bus.rvalid && bus.rready) r_p = 1'b1;

                if (tx_valid) begin
                    if (hold_on && (tx_data !== hold_val)) hold_err++;
                    if (tx_wait < tx_stall) begin
                        tx_ready = 1'b0; tx_wait++; hold_on = 1'b1; hold_val = tx_data;
                    end else begin
                        tx_ready = 1'b1; txq.push_back(tx_data); tx_wait = 0; hold_on = 1'b0;
                    end
                end else begin
                    tx_ready = 1'b0;
                    hold_on  = 1'b0;
                end
            end
        end
    end

    // Offer one byte (entered on a falling edge), with an optional idle gap first
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL rx_accept: rx_ready stuck at %0b, required 1", rx_ready);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [31:0] addr,
                              input logic [31:0] wdata, input int gap);
        send_byte(cmd, gap);
        if (cmd == 8'h57 || cmd == 8'h52) begin
            for (int i = 0; i < 4; i++) send_byte(addr[31-8*i -: 8], gap);
        end
        if (cmd == 8'h57) begin
            for (int i = 0; i < 4; i++) send_byte(wdata[31-8*i -: 8], gap);
        end
    endtask

    task automatic wait_tx(input int n);
        int k;
        k = 0;
        while (txq.size() < n && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2000) begin
            checks++; errors++;
            $display("FAIL tx_wait: got %0d bytes, required %0d", txq.size(), n);
        end
        repeat (8) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0]  cmd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] preload;
        bit          slverr;
        int          aw_dly;
        int          w_dly;
        int          stall;
        int          n_tx;
        logic [39:0] exp_tx;  // expected bytes, left-aligned, first byte in [39:32]
    } vec_t;

    vec_t        vecs [6];
    int          aw0, w0, ar0;
    logic [7:0]  expq [$];
    logic [31:0] ref_mem [logic [31:0]];

    initial begin
        vecs[0] = '{cmd: 8'h57, addr: 32'h0000_0010, wdata: 32'hDEAD_BEEF, preload: 32'h0,
                    slverr: 0, aw_dly: 0, w_dly: 0, stall: 0, n_tx: 1,
                    exp_tx: 40'h00_0000_0000};
        vecs[1] = '{cmd: 8'h52, addr: 32'h4000_0004, wdata: 32'h0, preload: 32'h1234_5678,
                    slverr: 0, aw_dly: 0, w_dly: 0, stall: 0, n_tx: 5,
                    exp_tx: 40'h00_1234_5678};
        vecs[2] = '{cmd: 8'h41, addr: 32'h0, wdata: 32'h0, preload: 32'h0,
                    slverr: 0, aw_dly: 0, w_dly: 0, stall: 0, n_tx: 1,
                    exp_tx: 40'hEE_0000_0000};
        vecs[3] = '{cmd: 8'h52, addr: 32'h4000_0004, wdata: 32'h0, preload: 32'h1234_5678,
                    slverr: 0, aw_dly: 0, w_dly: 0, stall: 0, n_tx: 5,
                    exp_tx: 40'h00_1234_5678};
        vecs[4] = '{cmd: 8'h57, addr: 32'h0000_0020, wdata: 32'hCAFE_F00D, preload: 32'h0,
                    slverr: 1, aw_dly: 0, w_dly: 3, stall: 0, n_tx: 1,
                    exp_tx: 40'h02_0000_0000};
        vecs[5] = '{cmd: 8'h52, addr: 32'h4000_0004, wdata: 32'h0, preload: 32'h1234_5678,
                    slverr: 0, aw_dly: 0, w_dly: 0, stall: 5, n_tx: 5,
                    exp_tx: 40'h00_1234_5678};

        // Reset values
        arstn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rx_ready", rx_ready, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_axi", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 0);
        arstn = 1'b1;
        @(negedge clk);
        check("rx_ready_after_release", rx_ready, 1);

        // Directed vectors
        for (int v = 0; v < 6; v++) begin
            force_slverr = vecs[v].slverr;
            aw_dly   = vecs[v].aw_dly;
            w_dly    = vecs[v].w_dly;
            ar_dly   = 0;
            tx_stall = vecs[v].stall;
            if (vecs[v].cmd == 8'h52) mem[vecs[v].addr] = vecs[v].preload;
            aw0 = aw_cnt; w0 = w_cnt; ar0 = ar_cnt;
            txq.delete();
            send_frame(vecs[v].cmd, vecs[v].addr, vecs[v].wdata, 0);
            wait_tx(vecs[v].n_tx);
            check($sformatf("v%0d_tx_len", v), txq.size(), vecs[v].n_tx);
            for (int i = 0; i < vecs[v].n_tx && i < txq.size(); i++) begin
                check($sformatf("v%0d_tx%0d", v, i), txq[i], vecs[v].exp_tx[39-8*i -: 8]);
            end
            if (vecs[v].cmd == 8'h57) begin
                check($sformatf("v%0d_aw_hs", v), aw_cnt - aw0, 1);
                check($sformatf("v%0d_w_hs", v), w_cnt - w0, 1);
                check($sformatf("v%0d_awaddr", v), cap_awaddr, vecs[v].addr);
                check($sformatf("v%0d_wdata", v), cap_wdata, vecs[v].wdata);
                check($sformatf("v%0d_wstrb", v), cap_wstrb, 4'hF);
                check($sformatf("v%0d_awprot", v), cap_awprot, 3'b000);
            end else if (vecs[v].cmd == 8'h52) begin
                check($sformatf("v%0d_ar_hs", v), ar_cnt - ar0, 1);
                check($sformatf("v%0d_araddr", v), cap_araddr, vecs[v].addr);
                check($sformatf("v%0d_arprot", v), cap_arprot, 3'b000);
            end else begin
                check($sformatf("v%0d_no_axi", v), (aw_cnt - aw0) + (w_cnt - w0) + (ar_cnt - ar0), 0);
            end
            check($sformatf("v%0d_tx_hold", v), hold_err, 0);
            check($sformatf("v%0d_rx_busy", v), busy_err, 0);
        end
        force_slverr = 1'b0;
        tx_stall = 0;

        // Reset after the third address byte of a read
        ar0 = ar_cnt;
        txq.delete();
        send_byte(8'h52, 0);
        send_byte(8'h40, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        arstn = 1'b0;
        #1;
        check("midrst_rx_ready", rx_ready, 0);
        check("midrst_tx", {tx_valid, tx_data}, 0);
        check("midrst_axi", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 0);
        @(negedge clk);
        arstn = 1'b1;
        @(negedge clk);
        check("midrst_rx_ready_release", rx_ready, 1);
        repeat (20) @(negedge clk);
        check("midrst_no_tx", txq.size(), 0);
        check("midrst_no_ar", ar_cnt - ar0, 0);
        send_frame(8'h52, 32'h4000_0004, 32'h0, 0);
        wait_tx(5);
        check("midrst_next_len", txq.size(), 5);
        if (txq.size() == 5) check("midrst_next_bytes",
            {txq[0], txq[1], txq[2], txq[3], txq[4]}, 40'h00_1234_5678);

`ifdef UART_AXIL_BRIDGE_RX_TIMEOUT_EN
        // Frame abandoned after two bytes
        txq.delete();
        aw0 = aw_cnt;
        send_byte(8'h57, 0);
        send_byte(8'h11, 0);
        wait_tx(1);
        check("timeout_len", txq.size(), 1);
        if (txq.size() == 1) check("timeout_byte", txq[0], 8'hEF);
        check("timeout_no_aw", aw_cnt - aw0, 0);
`endif

        // Random frames against the frame-level model
        for (int f = 0; f < 40; f++) begin
            int          op;
            int          gap;
            logic [7:0]  cmd;
            logic [7:0]  st;
            logic [31:0] addr;
            logic [31:0] wd;
            logic [31:0] rv;
            op   = int'($urandom_range(0, 9));
            addr = 32'h1000_0000 + 32'($urandom_range(0, 7)) * 32'd4;
            wd   = $urandom;
            gap  = int'($urandom_range(0, 2));
            aw_dly   = int'($urandom_range(0, 3));
            w_dly    = int'($urandom_range(0, 3));
            ar_dly   = int'($urandom_range(0, 3));
            tx_stall = int'($urandom_range(0, 2));
            expq.delete();
            st = (addr[3:0] == 4'hC) ? 8'h02 : 8'h00;
            if (op == 0) begin
                cmd = 8'($urandom);
                while (cmd == 8'h57 || cmd == 8'h52) cmd = 8'($urandom);
                expq.push_back(8'hEE);
            end else if (op < 5) begin
                cmd = 8'h57;
                expq.push_back(st);
                if (st == 8'h00) ref_mem[addr] = wd;
            end else begin
                cmd = 8'h52;
                rv  = ref_mem.exists(addr) ? ref_mem[addr] : 32'h0;
                expq.push_back(st);
                for (int i = 0; i < 4; i++) expq.push_back(rv[31-8*i -: 8]);
            end
            txq.delete();
            send_frame(cmd, addr, wd, gap);
            wait_tx(expq.size());
            check($sformatf("rnd%0d_len", f), txq.size(), expq.size());
            for (int i = 0; i < expq.size() && i < txq.size(); i++) begin
                check($sformatf("rnd%0d_b%0d", f, i), txq[i], expq[i]);
            end
        end

        check("axi_protocol", proto_err, 0);
        check("tx_hold_stable", hold_err, 0);
        check("rx_ready_while_busy", busy_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
